alu_arbiter: RTL

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arb_pkg.sv | 29 ++
 rtl/alu_rr_arbiter.sv | 44 ++++
 rtl/alu_arbiter.sv | 116 +++++++++++
 3 files changed

// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the two-requester ALU arbiter.
// ALU_ARB_FIXED_PRIO_EN (optional) switches grant selection from round-robin to fixed req0 priority.
package alu_arb_pkg;

  localparam int ALU_W = 4;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_EXEC = 2'd1;
  localparam state_t ST_RESP = 2'd2;

  localparam logic [3:0] ALU_ADD = 4'b1010;
  localparam logic [3:0] ALU_MUL = 4'b1100;

  // Round-robin pick: a lone requester always wins; on a tie the one not granted last wins.
  function automatic logic [1:0] rr_pick(input logic [1:0] valid, input logic last);
    logic [1:0] grant;
    grant = 2'b00;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
    return grant;
  endfunction

endpackage

// File: rtl/alu_rr_arbiter.sv
// Two-way grant selector owning the last-served pointer.
// With ALU_ARB_FIXED_PRIO_EN defined the pointer is removed and req0 always wins ties.
module alu_rr_arbiter
  import alu_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  input  logic       upd,
  input  logic       upd_id,
  output logic [1:0] grant
);

`ifdef ALU_ARB_FIXED_PRIO_EN
  // Fixed priority grant, req0 first.
  always_comb begin
    grant = 2'b00;
    if (valid[0]) begin
      grant = 2'b01;
    end else if (valid[1]) begin
      grant = 2'b10;
    end else begin
      grant = 2'b00;
    end
  end
`else
  logic last_r;

  // Last-served pointer; reset marks req1 as last so req0 wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_r <= 1'b1;
    end else if (upd) begin
      last_r <= upd_id;
    end
  end

  // Round-robin grant from the current pointer.
  always_comb begin
    grant = rr_pick(valid, last_r);
  end
`endif

endmodule

// File: rtl/alu_arbiter.sv
// Arbitrates two requesters onto one combinational ALU with fixed two-cycle accept-to-response latency.
// Grant policy is round-robin unless ALU_ARB_FIXED_PRIO_EN is defined (then req0 has fixed priority).
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int W = ALU_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  input  logic         req1_valid,
  output logic         req0_ready,
  output logic         req1_ready,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  input  logic [3:0]   req0_op,
  input  logic [3:0]   req1_op,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [3:0]   alu_op,
  input  logic [W-1:0] alu_x,
  input  logic [W-1:0] alu_y,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [W-1:0] rsp_x,
  output logic [W-1:0] rsp_y
);

  state_t     state_r;
  logic       owner_r;
  logic [1:0] valid_s;
  logic [1:0] grant_s;
  logic       accept_s;
  logic       upd_s;

  // Requests are only visible to the arbiter while idle, so ready stays low in EXEC/RESP.
  always_comb begin
    valid_s = 2'b00;
    if (state_r == ST_IDLE) begin
      valid_s = {req1_valid, req0_valid};
    end else begin
      valid_s = 2'b00;
    end
  end

  alu_rr_arbiter u_arb (
    .clk    (clk),
    .rst    (rst),
    .valid  (valid_s),
    .upd    (upd_s),
    .upd_id (rsp_id),
    .grant  (grant_s)
  );

  // Handshake decode for grant and pointer update.
  always_comb begin
    req0_ready = grant_s[0];
    req1_ready = grant_s[1];
    accept_s   = grant_s[0] | grant_s[1];
    upd_s      = (state_r == ST_RESP) & rsp_ready;
  end

  // Control FSM with the registered ALU drive and response outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      owner_r   <= 1'b0;
      alu_a     <= {W{1'b0}};
      alu_b     <= {W{1'b0}};
      alu_op    <= 4'b0000;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_x     <= {W{1'b0}};
      rsp_y     <= {W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            if (grant_s[1]) begin
              alu_a  <= req1_a;
              alu_b  <= req1_b;
              alu_op <= req1_op;
            end else begin
              alu_a  <= req0_a;
              alu_b  <= req0_b;
              alu_op <= req0_op;
            end
            owner_r <= grant_s[1];
            state_r <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          rsp_x     <= alu_x;
          rsp_y     <= alu_y;
          rsp_id    <= owner_r;
          rsp_valid <= 1'b1;
          state_r   <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state_r   <= ST_IDLE;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          state_r   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
